// File: rtl/seq_divider_rv.sv
//==============================================================================
// Module   : seq_divider_rv
// Purpose  : Sequential signed restoring divider with valid/ready handshakes.
//            Produces one quotient bit per cycle on operand magnitudes.
// Options  : DIV_ZERO_BYPASS_EN - a zero divisor skips the iterative phase.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_divider_rv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic [WIDTH-1:0] dvd_q,     dvd_d;
    logic             neg_a_q,   neg_a_d;
    logic             neg_b_q,   neg_b_d;
    logic             divz_q,    divz_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dz_out_q,  dz_out_d;
    logic             dv_q,      dv_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             q_bit;

    // Magnitude of a two's complement value; the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    // The partial remainder is always below the divisor, so bit WIDTH of the
    // difference acts as the borrow of the trial subtraction.
    always_comb begin
        rem_shift = {rem_q, a_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, b_q};
        q_bit     = ~rem_sub[WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        divz_d    = divz_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dz_out_d  = dz_out_q;
        dv_d      = dv_q;

        unique case (state_q)
            S_IDLE: begin
                if (src_valid) begin
                    a_d     = mag(Dividend);
                    b_d     = mag(Divisor);
                    dvd_d   = Dividend;
                    neg_a_d = Dividend[WIDTH-1];
                    neg_b_d = Divisor[WIDTH-1];
                    divz_d  = (Divisor == {WIDTH{1'b0}});
                    rem_d   = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
`ifdef DIV_ZERO_BYPASS_EN
                    state_d = (Divisor == {WIDTH{1'b0}}) ? S_FIX : S_CALC;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                rem_d = q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (divz_q) begin
                    quo_out_d = {WIDTH{1'b1}};
                    rem_out_d = dvd_q;
                    dz_out_d  = 1'b1;
                end else begin
                    quo_out_d = (neg_a_q ^ neg_b_q) ? ({WIDTH{1'b0}} - a_q) : a_q;
                    rem_out_d = neg_a_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
                    dz_out_d  = 1'b0;
                end
                dv_d    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (dst_ready) begin
                    dv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            dvd_q     <= {WIDTH{1'b0}};
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            divz_q    <= 1'b0;
            quo_out_q <= {WIDTH{1'b0}};
            rem_out_q <= {WIDTH{1'b0}};
            dz_out_q  <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            divz_q    <= divz_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dz_out_q  <= dz_out_d;
            dv_q      <= dv_d;
        end
    end

    assign src_ready   = (state_q == S_IDLE);
    assign dst_valid   = dv_q;
    assign Quotient    = quo_out_q;
    assign Remainder   = rem_out_q;
    assign div_by_zero = dz_out_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_rv.sv
//==============================================================================
// Module   : tb_seq_divider_rv
// Purpose  : Directed self-checking bench for seq_divider_rv.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_divider_rv;

    logic        clk;
    logic        reset;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] Dividend;
    logic [15:0] Divisor;
    logic        dst_valid;
    logic        dst_ready;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        div_by_zero;

    int pass_cnt;
    int total_cnt;

    seq_divider_rv #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .dst_valid   (dst_valid),
        .dst_ready   (dst_ready),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 17;
`endif

    // Issues one operation and returns the first result plus edges from accept to dst_valid.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b, input logic rdy,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic dz, output int lat);
        int n;
        n = 0;
        while (!src_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        src_valid = 1'b1;
        Dividend  = a;
        Divisor   = b;
        dst_ready = rdy;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        Dividend  = 16'h5A5A;
        Divisor   = 16'h0000;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (dst_valid) begin
                lat = k;
                break;
            end
        end
        q  = Quotient;
        r  = Remainder;
        dz = div_by_zero;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if (dst_valid !== 1'b0) $display("FAIL reset_dst_valid: got %b want 0", dst_valid);
        else pass_cnt++;
        total_cnt++;
        if (src_ready !== 1'b1) $display("FAIL reset_src_ready: got %b want 1", src_ready);
        else pass_cnt++;
        total_cnt++;
        if (Quotient !== 16'h0000 || Remainder !== 16'h0000 || div_by_zero !== 1'b0)
            $display("FAIL reset_outputs: got q=%h r=%h dz=%b want 0000 0000 0",
                     Quotient, Remainder, div_by_zero);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [15:0] q, r;
        logic dz;
        int lat;
        run_div(16'd100, 16'd7, 1'b1, q, r, dz, lat);
        total_cnt++;
        if (q !== 16'd14) $display("FAIL basic_q: got %h want %h", q, 16'd14);
        else pass_cnt++;
        total_cnt++;
        if (r !== 16'd2) $display("FAIL basic_r: got %h want %h", r, 16'd2);
        else pass_cnt++;
        total_cnt++;
        if (dz !== 1'b0) $display("FAIL basic_dz: got %b want 0", dz);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 17) $display("FAIL basic_latency: got %0d want 17", lat);
        else pass_cnt++;
    endtask

    task automatic test_signs();
        logic [15:0] q, r;
        logic dz;
        int lat;
        run_div(16'hFF9C, 16'd7, 1'b1, q, r, dz, lat);      // -100 / 7
        total_cnt++;
        if (q !== 16'hFFF2 || r !== 16'hFFFE)
            $display("FAIL neg_dividend: got q=%h r=%h want fff2 fffe", q, r);
        else pass_cnt++;
        run_div(16'd100, 16'hFFF9, 1'b1, q, r, dz, lat);    // 100 / -7
        total_cnt++;
        if (q !== 16'hFFF2 || r !== 16'h0002)
            $display("FAIL neg_divisor: got q=%h r=%h want fff2 0002", q, r);
        else pass_cnt++;
        run_div(16'hFF9C, 16'hFFF9, 1'b1, q, r, dz, lat);   // -100 / -7
        total_cnt++;
        if (q !== 16'h000E || r !== 16'hFFFE)
            $display("FAIL neg_both: got q=%h r=%h want 000e fffe", q, r);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        logic [15:0] q, r;
        logic dz;
        int lat;
        run_div(16'd100, 16'd0, 1'b1, q, r, dz, lat);
        total_cnt++;
        if (q !== 16'hFFFF || r !== 16'd100 || dz !== 1'b1)
            $display("FAIL div_zero_pos: got q=%h r=%h dz=%b want ffff 0064 1", q, r, dz);
        else pass_cnt++;
        total_cnt++;
        if (lat !== ZERO_LAT) $display("FAIL div_zero_latency: got %0d want %0d", lat, ZERO_LAT);
        else pass_cnt++;
        run_div(16'hFFFB, 16'd0, 1'b1, q, r, dz, lat);      // -5 / 0
        total_cnt++;
        if (q !== 16'hFFFF || r !== 16'hFFFB || dz !== 1'b1)
            $display("FAIL div_zero_neg: got q=%h r=%h dz=%b want ffff fffb 1", q, r, dz);
        else pass_cnt++;
    endtask

    task automatic test_edges();
        logic [15:0] q, r;
        logic dz;
        int lat;
        run_div(16'h8000, 16'hFFFF, 1'b1, q, r, dz, lat);   // -32768 / -1
        total_cnt++;
        if (q !== 16'h8000 || r !== 16'h0000 || dz !== 1'b0)
            $display("FAIL overflow: got q=%h r=%h dz=%b want 8000 0000 0", q, r, dz);
        else pass_cnt++;
        run_div(16'd0, 16'd5, 1'b1, q, r, dz, lat);
        total_cnt++;
        if (q !== 16'h0000 || r !== 16'h0000)
            $display("FAIL zero_dividend: got q=%h r=%h want 0000 0000", q, r);
        else pass_cnt++;
        run_div(16'd7, 16'd100, 1'b1, q, r, dz, lat);
        total_cnt++;
        if (q !== 16'h0000 || r !== 16'h0007)
            $display("FAIL small_dividend: got q=%h r=%h want 0000 0007", q, r);
        else pass_cnt++;
        run_div(16'h7FFF, 16'h8000, 1'b1, q, r, dz, lat);   // 32767 / -32768
        total_cnt++;
        if (q !== 16'h0000 || r !== 16'h7FFF)
            $display("FAIL max_by_min: got q=%h r=%h want 0000 7fff", q, r);
        else pass_cnt++;
        run_div(16'h8000, 16'd3, 1'b1, q, r, dz, lat);      // -32768 / 3
        total_cnt++;
        if (q !== 16'hD556 || r !== 16'hFFFE)
            $display("FAIL min_by_three: got q=%h r=%h want d556 fffe", q, r);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [15:0] q, r;
        logic dz;
        int lat;
        run_div(16'd1234, 16'd10, 1'b0, q, r, dz, lat);
        total_cnt++;
        if (q !== 16'd123 || r !== 16'd4 || lat !== 17)
            $display("FAIL bp_result: got q=%h r=%h lat=%0d want 007b 0004 17", q, r, lat);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (dst_valid !== 1'b1 || src_ready !== 1'b0 ||
                Quotient !== 16'd123 || Remainder !== 16'd4)
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b q=%h r=%h want 1 0 007b 0004",
                         i, dst_valid, src_ready, Quotient, Remainder);
            else pass_cnt++;
        end
        dst_ready = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (dst_valid !== 1'b0 || src_ready !== 1'b1 || Quotient !== 16'd123)
            $display("FAIL bp_release: got v=%b rdy=%b q=%h want 0 1 007b",
                     dst_valid, src_ready, Quotient);
        else pass_cnt++;
    endtask

    task automatic test_reset_midcalc();
        logic [15:0] q, r;
        logic dz;
        int lat;
        @(negedge clk);
        src_valid = 1'b1;
        Dividend  = 16'd1000;
        Divisor   = 16'd3;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (dst_valid !== 1'b0 || Quotient !== 16'h0000 ||
            Remainder !== 16'h0000 || div_by_zero !== 1'b0)
            $display("FAIL midreset_outputs: got v=%b q=%h r=%h dz=%b want 0 0000 0000 0",
                     dst_valid, Quotient, Remainder, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (src_ready !== 1'b1) $display("FAIL midreset_src_ready: got %b want 1", src_ready);
        else pass_cnt++;
        run_div(16'd9, 16'd3, 1'b1, q, r, dz, lat);
        total_cnt++;
        if (q !== 16'd3 || r !== 16'd0 || lat !== 17)
            $display("FAIL midreset_next: got q=%h r=%h lat=%0d want 0003 0000 17", q, r, lat);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        src_valid = 1'b0;
        Dividend  = 16'h0000;
        Divisor   = 16'h0000;
        dst_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_edges();
        test_backpressure();
        test_reset_midcalc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
